// File: rtl/gumnut_ctrl.sv
// gumnut_ctrl -- instruction sequencing FSM for the Gumnut core.
// Walks FETCH/DECODE/EXECUTE/MEM/WB, handles interrupts and the WAIT state,
// and drives the instruction and data/port bus handshakes.
// Optional feature: define GUMNUT_BUS_TIMEOUT_EN to abort a bus cycle that
// has gone unacknowledged for 15 cycles (bus_err_o pulses, fetch restarts).
module gumnut_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic [6:0] op_i,
  input  logic [2:0] func_i,
  input  logic       inst_ack_i,
  input  logic       data_ack_i,
  input  logic       int_req_i,
  output logic       inst_cyc_o,
  output logic       inst_stb_o,
  output logic       data_cyc_o,
  output logic       data_stb_o,
  output logic       data_we_o,
  output logic       port_o,
  output logic       alu_en_o,
  output logic       reg_wr_o,
  output logic       wb_mem_o,
  output logic       pc_inc_o,
  output logic       pc_ld_o,
  output logic       ret_o,
  output logic       int_ack_o,
  output logic       ie_o,
  output logic [2:0] state_o,
  output logic       bus_err_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_INT    = 3'd5,
    S_WAIT   = 3'd6
  } st_e;

  typedef enum logic [2:0] {K_NOP, K_ALU, K_MEM, K_JMP, K_MISC} kind_e;

  st_e        state;
  kind_e      kind, dkind;
  logic [1:0] msub;    // memory sub-op: 00 ldm, 01 stm, 10 inp, 11 out
  logic [2:0] mfunc;   // misc sub-op
  logic       ie;
  logic       live;    // low from reset until the first enabled cycle after it
  logic       fetching, mem_cyc, tmo_hit;

  // Entering FETCH with interrupts enabled and a request pending skips the
  // bus cycle and takes the interrupt instead.
  function automatic st_e fetch_entry(input logic ie_n, input logic irq);
    return (ie_n && irq) ? S_INT : S_FETCH;
  endfunction

  // Opcode class decode from the instruction's top bits.
  always_comb begin
    dkind = K_NOP;
    if (!op_i[6])                    dkind = K_ALU;
    else if (op_i[6:5] == 2'b10)     dkind = K_MEM;
    else if (op_i[6:4] == 3'b110)    dkind = K_ALU;
    else if (op_i[6:3] == 4'b1110)   dkind = K_ALU;
    else if (op_i[6:2] == 5'b11110)  dkind = K_JMP;
    else if (op_i[6:1] == 6'b111110) dkind = K_JMP;
    else if (op_i == 7'b1111110)     dkind = K_MISC;
  end

  assign fetching = live && (state == S_FETCH) && !tmo_hit;
  assign mem_cyc  = (state == S_MEM) && !tmo_hit;

`ifdef GUMNUT_BUS_TIMEOUT_EN
  logic [3:0] tmo;

  // Count unacknowledged bus cycles; any ack, the abort itself, or being
  // outside a bus state clears it.
  always_ff @(posedge clk) begin
    if (!rst)
      tmo <= '0;
    else if (cen) begin
      if (!(fetching || mem_cyc) || (fetching && inst_ack_i) || (mem_cyc && data_ack_i))
        tmo <= '0;
      else
        tmo <= tmo + 4'd1;
    end
  end

  assign tmo_hit   = (tmo == 4'hF);
  assign bus_err_o = tmo_hit;
`else
  assign tmo_hit   = 1'b0;
  assign bus_err_o = 1'b0;
`endif

  // Main sequencer: state, interrupt enable and the latched instruction class.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_FETCH;
      ie    <= 1'b0;
      live  <= 1'b0;
      kind  <= K_NOP;
      msub  <= '0;
      mfunc <= '0;
    end else if (cen) begin
      live <= 1'b1;
      if (live) begin
        case (state)
          S_FETCH: begin
            if (tmo_hit)         state <= fetch_entry(ie, int_req_i);
            else if (inst_ack_i) state <= S_DECODE;
          end
          S_DECODE: begin
            state <= S_EXEC;
            kind  <= dkind;
            msub  <= op_i[4:3];
            mfunc <= func_i;
          end
          S_EXEC: begin
            case (kind)
              K_ALU: state <= S_WB;
              K_MEM: state <= S_MEM;
              K_MISC: begin
                case (mfunc)
                  3'b001, 3'b010: begin         // reti, enai
                    ie    <= 1'b1;
                    state <= fetch_entry(1'b1, int_req_i);
                  end
                  3'b011: begin                 // disi
                    ie    <= 1'b0;
                    state <= S_FETCH;
                  end
                  3'b100, 3'b101: state <= S_WAIT;
                  default: state <= fetch_entry(ie, int_req_i);
                endcase
              end
              default: state <= fetch_entry(ie, int_req_i);  // jump, branch, nop
            endcase
          end
          S_MEM: begin
            if (tmo_hit)         state <= fetch_entry(ie, int_req_i);
            else if (data_ack_i) state <= msub[0] ? fetch_entry(ie, int_req_i) : S_WB;
          end
          S_WB:   state <= fetch_entry(ie, int_req_i);
          S_INT: begin
            ie    <= 1'b0;
            state <= S_FETCH;
          end
          S_WAIT: if (ie && int_req_i) state <= S_INT;
          default: state <= S_FETCH;
        endcase
      end
    end
  end

  assign inst_cyc_o = fetching;
  assign inst_stb_o = fetching;
  assign pc_inc_o   = fetching && inst_ack_i && cen;
  assign data_cyc_o = mem_cyc;
  assign data_stb_o = mem_cyc;
  assign data_we_o  = mem_cyc && msub[0];
  assign port_o     = mem_cyc && msub[1];
  assign alu_en_o   = (state == S_EXEC) && (kind == K_ALU);
  assign pc_ld_o    = (state == S_EXEC) && (kind == K_JMP);
  assign ret_o      = (state == S_EXEC) && (kind == K_MISC) && (mfunc[2:1] == 2'b00);
  assign reg_wr_o   = (state == S_WB);
  assign wb_mem_o   = (state == S_WB) && (kind == K_MEM) && !msub[0];
  assign int_ack_o  = (state == S_INT);
  assign ie_o       = ie;
  assign state_o    = state;

endmodule

// File: tb/tb_gumnut_ctrl.sv
// tb_gumnut_ctrl -- directed and randomized checks of gumnut_ctrl against a
// per-instruction cycle model built from the instruction-class rules.
module tb_gumnut_ctrl;
  logic       clk = 1'b0, rst = 1'b0, cen = 1'b1;
  logic [6:0] op_i = '0;
  logic [2:0] func_i = '0;
  logic       inst_ack_i = 1'b0, data_ack_i = 1'b0, int_req_i = 1'b0;
  logic       inst_cyc_o, inst_stb_o, data_cyc_o, data_stb_o, data_we_o, port_o;
  logic       alu_en_o, reg_wr_o, wb_mem_o, pc_inc_o, pc_ld_o, ret_o, int_ack_o, ie_o;
  logic [2:0] state_o;
  logic       bus_err_o;

  always #5 clk = ~clk;

  gumnut_ctrl dut (
    .clk(clk), .rst(rst), .cen(cen), .op_i(op_i), .func_i(func_i),
    .inst_ack_i(inst_ack_i), .data_ack_i(data_ack_i), .int_req_i(int_req_i),
    .inst_cyc_o(inst_cyc_o), .inst_stb_o(inst_stb_o), .data_cyc_o(data_cyc_o),
    .data_stb_o(data_stb_o), .data_we_o(data_we_o), .port_o(port_o),
    .alu_en_o(alu_en_o), .reg_wr_o(reg_wr_o), .wb_mem_o(wb_mem_o),
    .pc_inc_o(pc_inc_o), .pc_ld_o(pc_ld_o), .ret_o(ret_o), .int_ack_o(int_ack_o),
    .ie_o(ie_o), .state_o(state_o), .bus_err_o(bus_err_o)
  );

  localparam int O_ICYC = 14, O_ISTB = 13, O_DCYC = 12, O_DSTB = 11, O_WE = 10;
  localparam int O_PORT = 9, O_ALU = 8, O_RW = 7, O_WBM = 6, O_PCI = 5, O_PCL = 4;
  localparam int O_RET = 3, O_IACK = 2, O_IE = 1, O_BERR = 0;

  logic [14:0] obs;
  assign obs = {inst_cyc_o, inst_stb_o, data_cyc_o, data_stb_o, data_we_o, port_o,
                alu_en_o, reg_wr_o, wb_mem_o, pc_inc_o, pc_ld_o, ret_o, int_ack_o,
                ie_o, bus_err_o};

  // One expected cycle: inputs to drive and outputs/state to expect.
  typedef struct {
    logic [6:0]  op;
    logic [2:0]  fn;
    logic        ia, da, irq, cen;
    logic [2:0]  st;
    logic [14:0] o, m;
  } rec_t;

  rec_t q[$];
  int   tests = 0, fails = 0;
  logic mie = 1'b0;      // model interrupt-enable flag
  logic irq_lvl = 1'b0;  // interrupt request level for generated cycles

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic rec_t mk(input logic [2:0] st, input logic [6:0] op, input logic [2:0] fn);
    rec_t r;
    r.op = op; r.fn = fn; r.st = st;
    r.o = '0; r.o[O_IE] = mie;
    r.ia = 1'($urandom_range(1)); r.da = 1'($urandom_range(1));
    r.irq = irq_lvl; r.cen = 1'b1; r.m = '1;
    return r;
  endfunction

  // Expected cycles of one instruction from fetch to its last cycle.
  task automatic gen(input logic [6:0] op, input logic [2:0] fn, input int wi,
                     input int wd, input int nwait);
    rec_t r;
    int   cls;  // 0 nop, 1 alu, 2 mem, 3 jump/branch, 4 misc
    casez (op)
      7'b0??????: cls = 1;
      7'b10?????: cls = 2;
      7'b110????: cls = 1;
      7'b1110???: cls = 1;
      7'b11110??: cls = 3;
      7'b111110?: cls = 3;
      7'b1111110: cls = 4;
      default:    cls = 0;
    endcase
    for (int k = 0; k <= wi; k++) begin
      r = mk(3'd0, op, fn);
      r.o[O_ICYC] = 1'b1; r.o[O_ISTB] = 1'b1;
      r.ia = (k == wi); r.o[O_PCI] = (k == wi);
      q.push_back(r);
    end
    q.push_back(mk(3'd1, op, fn));
    r = mk(3'd2, op, fn);
    r.o[O_ALU] = (cls == 1);
    r.o[O_PCL] = (cls == 3);
    r.o[O_RET] = (cls == 4) && (fn == 3'd0 || fn == 3'd1);
    q.push_back(r);
    if (cls == 4 && (fn == 3'd1 || fn == 3'd2)) mie = 1'b1;
    if (cls == 4 && fn == 3'd3) mie = 1'b0;
    if (cls == 2) begin
      for (int k = 0; k <= wd; k++) begin
        r = mk(3'd3, op, fn);
        r.o[O_DCYC] = 1'b1; r.o[O_DSTB] = 1'b1;
        r.o[O_WE] = op[3]; r.o[O_PORT] = op[4];
        r.da = (k == wd);
        q.push_back(r);
      end
    end
    if (cls == 1 || (cls == 2 && !op[3])) begin
      r = mk(3'd4, op, fn);
      r.o[O_RW] = 1'b1; r.o[O_WBM] = (cls == 2);
      q.push_back(r);
    end
    if (cls == 4 && (fn == 3'd4 || fn == 3'd5)) begin
      for (int k = 0; k < nwait; k++) begin
        r = mk(3'd6, op, fn);
        r.irq = (k == nwait - 1);
        q.push_back(r);
      end
      r = mk(3'd5, op, fn); r.o[O_IACK] = 1'b1; r.irq = 1'b0;
      q.push_back(r);
      mie = 1'b0;
    end else if (mie && irq_lvl) begin
      r = mk(3'd5, op, fn); r.o[O_IACK] = 1'b1;
      q.push_back(r);
      mie = 1'b0;
    end
  endtask

  task automatic step(input rec_t r, input string tag);
    op_i = r.op; func_i = r.fn; inst_ack_i = r.ia; data_ack_i = r.da;
    int_req_i = r.irq; cen = r.cen;
    @(negedge clk);
    chk({tag, " state"}, {12'd0, state_o}, {12'd0, r.st});
    chk({tag, " outs"}, obs & r.m, r.o & r.m);
    @(posedge clk); #1;
  endtask

  // Play n queued cycles (all when n < 0), optionally with random cen stalls.
  task automatic play(input string tag, input bit stalls, input int n);
    rec_t r, s;
    int   k;
    k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      r = q.pop_front();
      if (stalls && $urandom_range(4) == 0) begin
        s = r; s.cen = 1'b0;
        s.ia = 1'($urandom_range(1)); s.da = 1'($urandom_range(1));
        s.m[O_PCI] = 1'b0;
        step(s, {tag, " stall"});
      end
      step(r, tag);
      k++;
    end
    q.delete();
  endtask

  task automatic idle();
    inst_ack_i = 1'b0; data_ack_i = 1'b0; int_req_i = 1'b0; cen = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rec_t r;
    logic [6:0] op;
    logic [2:0] fn;

    // reset holds every output low
    rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      r = mk(3'd0, 7'd0, 3'd0); r.ia = 1'b1; r.da = 1'b1;
      step(r, "reset");
    end
    rst = 1'b1;
    idle();

    // ALU immediate, zero-wait: 0,1,2,4
    gen(7'b0000000, 3'd0, 0, 0, 0);
    play("alu", 1'b0, -1);

    // ldm with data ack after 3 wait cycles
    gen(7'b1000000, 3'd0, 0, 3, 0);
    play("ldm", 1'b0, -1);

    // stm, inp, out, jump, branch
    gen(7'b1001000, 3'd0, 1, 0, 0); play("stm", 1'b0, -1);
    gen(7'b1010000, 3'd0, 0, 2, 0); play("inp", 1'b0, -1);
    gen(7'b1011000, 3'd0, 2, 1, 0); play("out", 1'b0, -1);
    gen(7'b1111000, 3'd0, 0, 0, 0); play("jump", 1'b0, -1);
    gen(7'b1111100, 3'd0, 0, 0, 0); play("branch", 1'b0, -1);
    gen(7'b1111111, 3'd0, 0, 0, 0); play("nop", 1'b0, -1);

    // enai with a pending request: interrupt taken instead of the next fetch
    irq_lvl = 1'b1;
    gen(7'b1111110, 3'd2, 0, 0, 0);
    play("enai-int", 1'b0, -1);
    irq_lvl = 1'b0;
    gen(7'b0000001, 3'd0, 0, 0, 0);
    play("post-int", 1'b0, -1);

    // wait with ie set: 10 WAIT cycles, then interrupt
    gen(7'b1111110, 3'd2, 0, 0, 0);
    gen(7'b1111110, 3'd4, 0, 0, 10);
    play("wait", 1'b0, -1);

    // ret and reti
    gen(7'b1111110, 3'd0, 0, 0, 0); play("ret", 1'b0, -1);
    gen(7'b1111110, 3'd1, 0, 0, 0); play("reti", 1'b0, -1);
    gen(7'b1111110, 3'd3, 0, 0, 0); play("disi", 1'b0, -1);

    // reset while a data cycle is strobing
    gen(7'b1000000, 3'd0, 0, 5, 0);
    play("mem-rst", 1'b0, 4);
    rst = 1'b0;
    r = mk(3'd3, 7'b1000000, 3'd0);
    r.o[O_DCYC] = 1'b1; r.o[O_DSTB] = 1'b1; r.da = 1'b0;
    step(r, "mem-rst pre");
    mie = 1'b0;
    for (int k = 0; k < 2; k++) begin
      r = mk(3'd0, 7'b1000000, 3'd0); r.ia = 1'b1; r.da = 1'b1;
      step(r, "mem-rst held");
    end
    rst = 1'b1;
    idle();
    gen(7'b0100000, 3'd0, 0, 0, 0);
    play("refetch", 1'b0, -1);

    // unacknowledged fetch
`ifdef GUMNUT_BUS_TIMEOUT_EN
    for (int k = 0; k < 15; k++) begin
      r = mk(3'd0, 7'd0, 3'd0);
      r.o[O_ICYC] = 1'b1; r.o[O_ISTB] = 1'b1; r.ia = 1'b0;
      q.push_back(r);
    end
    r = mk(3'd0, 7'd0, 3'd0); r.o[O_BERR] = 1'b1;
    q.push_back(r);
`else
    for (int k = 0; k < 20; k++) begin
      r = mk(3'd0, 7'd0, 3'd0);
      r.o[O_ICYC] = 1'b1; r.o[O_ISTB] = 1'b1; r.ia = 1'b0;
      q.push_back(r);
    end
`endif
    gen(7'b0000000, 3'd0, 0, 0, 0);
    play("timeout", 1'b0, -1);

    // randomized instruction stream with random waits and cen stalls
    for (int n = 0; n < 80; n++) begin
      op = 7'($urandom_range(127));
      fn = 3'($urandom_range(7));
      if (op == 7'b1111110 && (fn == 3'd4 || fn == 3'd5)) fn = 3'd6;
      gen(op, fn, $urandom_range(3), $urandom_range(3), 0);
      play("rand", 1'b1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
